scs8hd_rrarb4: RTL
==================

Name: scs8hd_rrarb4

Overview:
Round-robin arbiter and sequencer that shares one AND-OR datapath resource between four requesters. Examples of that resource are a32o-style select/merge logic and a shared output driver. It issues a registered one-hot grant, bounds how long any one owner may hold the resource, and inserts a one-cycle release gap between owners so that the shared node never sees overlapping enables. It sits between requester control logic and the shared resource enable pins.

Parameters:
NREQ, 4, number of requesters; fixed at 4, and other values are unsupported.
MAX_HOLD, 8, maximum number of consecutive cycles one grant may be held; legal range 1..255.
CW, 8, width of the hold counter; must satisfy 2^CW > MAX_HOLD.

Ports:
CLK  input  1  clock; rising-edge active.
RESET  input  1  asynchronous, active-high reset.
REQ  input  4  per-requester request; level-sensitive.
DONE  input  1  owner-signalled early release; sampled only in GRANT.
GNT  output  4  one-hot or zero grant; registered.
BUSY  output  1  high while in GRANT.
OWNER  output  2  encoded index of current or last owner; registered.
TIMEOUT  output  1  one-cycle pulse when a grant ends because MAX_HOLD was reached.

Behaviour:
- Reset values: RESET high forces asynchronously GNT=0, BUSY=0, OWNER=0, TIMEOUT=0, state=IDLE, hold counter=0, priority pointer=0.
- States: IDLE, GRANT, RELEASE.
- IDLE
  - If REQ!=0, select the first set bit scanning upward from the priority pointer, wrapping 3->0.
  - On the next edge: GNT=onehot(sel), OWNER=sel, counter=1, state=GRANT.
  - Latency from REQ to GNT is 1 cycle.
  - If REQ==0, remain in IDLE with GNT=0.
- GRANT
  - Release occurs when any of the following holds: REQ[OWNER]==0, DONE==1, or counter==MAX_HOLD.
  - On release: GNT=0, BUSY=0, pointer=(OWNER+1) mod 4, state=RELEASE.
  - TIMEOUT=1 for exactly one cycle, only if release was caused by the counter alone, i.e. REQ[OWNER]==1 and DONE==0.
  - Otherwise the counter increments and GNT holds.
  - The counter saturates and never wraps.
- RELEASE
  - Exactly one cycle with GNT=0, then IDLE.
  - This guarantees at least one dead cycle between owners, including when the same requester is re-granted.
- Arbitration is skipped in RELEASE; requests arriving in RELEASE are seen in the following IDLE cycle.
- Fairness: under continuous REQ=4'b1111 with MAX_HOLD=M, grants rotate 0,1,2,3,0,...
  - Each grant lasts M cycles.
  - Each grant is followed by 1 RELEASE cycle and 1 IDLE cycle.
- Simultaneous events:
  - DONE and timeout in the same cycle: DONE wins, so TIMEOUT=0.
  - REQ drop and DONE in the same cycle: a single release, with TIMEOUT=0.
- Requests from non-owners during GRANT are ignored; they do not preempt.
- Reset asserted mid-GRANT: GNT drops in the same cycle (asynchronous) and the pointer returns to 0.
- Reset deassertion is synchronised externally; the block only requires RESET to be stable around CLK edges.
- OWNER retains its last value in IDLE and RELEASE.
- Invariants:
  - GNT is never more than one-hot.
  - GNT!=0 implies BUSY==1 and GNT==onehot(OWNER).

Optional Feature:
Macro SCS8HD_RRARB_LOCK_EN.
- When defined, an extra input port LOCK (1 bit) exists.
  - While in GRANT with LOCK==1, the MAX_HOLD timeout is suppressed; the counter still saturates.
  - Only a REQ drop or DONE releases the grant, and TIMEOUT never pulses.
- When undefined, there is no LOCK port and the timeout always applies.

Decomposition:
- Shared package scs8hd_rrarb_pkg holds:
  - state enum (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2);
  - the NREQ constant;
  - the rotate-priority-select function.
- One sub-module, scs8hd_rrarb_pick4: purely combinational rotating priority encoder.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: sel[1:0], any.
  - Built from AND-OR terms.
- FSM, counter and output registers stay in the top module.

Test Plan:
1. Reset: hold RESET=1 with REQ=4'b1111 -> GNT=0, BUSY=0, OWNER=0, TIMEOUT=0. Assert RESET mid-GRANT -> GNT=0 in the same cycle, without waiting for a clock edge.
2. Single requester: REQ=4'b0100 at cycle 0 -> GNT=4'b0100 at cycle 1. Drop REQ at cycle 4 -> GNT=0 at cycle 5, RELEASE at cycle 5, IDLE at cycle 6, pointer=3.
3. Rotation and timeout: MAX_HOLD=3, REQ=4'b1111 held -> GNT sequence 0001x3, 0, 0, 0010x3, 0, 0, 0100x3, ...; TIMEOUT pulses once at the end of each grant.
4. Early DONE coincident with timeout: MAX_HOLD=2, REQ=4'b0001, DONE=1 on the second grant cycle -> release with TIMEOUT=0.
5. Wrap and skip: pointer=3 with REQ=4'b0110 -> grant index 1. Then REQ=4'b1001 with pointer=2 -> grant index 3, then index 0.
6. Same-owner re-grant: REQ=4'b0001 held, MAX_HOLD=2 -> GNT pattern 1,1,0,0,1,1,0,0. With SCS8HD_RRARB_LOCK_EN and LOCK=1 -> GNT stays at 1 indefinitely and TIMEOUT=0.

Source files
------------

// File: rtl/scs8hd_rrarb_pkg.sv
// scs8hd_rrarb_pkg: shared state encoding, requester count and rotating priority select.
package scs8hd_rrarb_pkg;

    localparam int NREQ = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Returns {any, sel}: first set bit of req at or above ptr, wrapping 3->0.
    // req is rotated so ptr lands at bit 0, then a fixed AND-OR priority
    // encoder finds the offset, which is added back onto ptr.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [7:0] d;
        logic [3:0] r;
        logic [1:0] o;
        d    = {req, req};
        r    = d[ptr +: 4];
        o[0] = (~r[0] & r[1]) | (~r[0] & ~r[1] & ~r[2] & r[3]);
        o[1] = ~r[0] & ~r[1] & (r[2] | r[3]);
        return {|req, o + ptr};
    endfunction

endpackage

// File: rtl/scs8hd_rrarb4_if.sv
// scs8hd_rrarb4_if: requester-side bundle of the arbiter.
//   REQ/DONE (and LOCK when SCS8HD_RRARB_LOCK_EN is defined) flow to the arbiter;
//   GNT/BUSY/OWNER/TIMEOUT flow back. slave = arbiter side, master = requester side.
interface scs8hd_rrarb4_if;
    import scs8hd_rrarb_pkg::*;

    logic [NREQ-1:0] REQ;
    logic            DONE;
    logic [NREQ-1:0] GNT;
    logic            BUSY;
    logic [1:0]      OWNER;
    logic            TIMEOUT;
`ifdef SCS8HD_RRARB_LOCK_EN
    logic            LOCK;
`endif

    modport slave (
`ifdef SCS8HD_RRARB_LOCK_EN
        input  LOCK,
`endif
        input  REQ, DONE,
        output GNT, BUSY, OWNER, TIMEOUT
    );

    modport master (
`ifdef SCS8HD_RRARB_LOCK_EN
        output LOCK,
`endif
        output REQ, DONE,
        input  GNT, BUSY, OWNER, TIMEOUT
    );

endinterface

// File: rtl/scs8hd_rrarb_pick4.sv
// scs8hd_rrarb_pick4: combinational rotating priority encoder.
//   req_i[3:0] requests, ptr_i[1:0] highest-priority index;
//   sel_o[1:0] chosen index, any_o high when any request is set.
module scs8hd_rrarb_pick4
    import scs8hd_rrarb_pkg::*;
(
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [1:0] sel_o,
    output logic       any_o
);

    assign {any_o, sel_o} = rr_pick(req_i, ptr_i);

endmodule

// File: rtl/scs8hd_rrarb4.sv
// scs8hd_rrarb4: 4-way round-robin arbiter with bounded hold and one-cycle release gap.
//   CLK, RESET (async, active-high); bus.slave carries REQ, DONE, GNT, BUSY, OWNER, TIMEOUT.
//   Optional SCS8HD_RRARB_LOCK_EN adds bus.LOCK, which suppresses the MAX_HOLD timeout.
module scs8hd_rrarb4
    import scs8hd_rrarb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 8,
    parameter int CW       = 8
) (
    input logic            CLK,
    input logic            RESET,
    scs8hd_rrarb4_if.slave bus
);

    localparam logic [CW-1:0] MAXC = CW'(MAX_HOLD);

    state_t          state_q;
    logic [NREQ-1:0] gnt_q;
    logic [1:0]      owner_q;
    logic [1:0]      ptr_q;
    logic [CW-1:0]   cnt_q;
    logic            timeout_q;
    logic [1:0]      sel;
    logic            any;
    logic            hit;
    logic            rel;

    scs8hd_rrarb_pick4 u_pick (
        .req_i (bus.REQ),
        .ptr_i (ptr_q),
        .sel_o (sel),
        .any_o (any)
    );

`ifdef SCS8HD_RRARB_LOCK_EN
    assign hit = (cnt_q == MAXC) && !bus.LOCK;
`else
    assign hit = (cnt_q == MAXC);
`endif
    assign rel = !bus.REQ[owner_q] || bus.DONE || hit;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    timeout_q <= 1'b0;
                    if (any) begin
                        state_q <= GRANT;
                        gnt_q   <= NREQ'(1) << sel;
                        owner_q <= sel;
                        cnt_q   <= CW'(1);
                    end
                end
                GRANT: begin
                    if (rel) begin
                        state_q   <= RELEASE;
                        gnt_q     <= '0;
                        ptr_q     <= owner_q + 2'd1;
                        // Only a pure hold-limit release pulses; REQ drop or DONE wins.
                        timeout_q <= hit && bus.REQ[owner_q] && !bus.DONE;
                    end else begin
                        cnt_q <= (cnt_q == MAXC) ? cnt_q : cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    timeout_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.GNT     = gnt_q;
    assign bus.BUSY    = (state_q == GRANT);
    assign bus.OWNER   = owner_q;
    assign bus.TIMEOUT = timeout_q;

endmodule
